dac_channel_scheduler: RTL

Sequences per-sample writes of up to four oscillator voices onto the single MAX5134 DAC SPI link. Generates the sample-rate tick, requests a 16-bit sample from each enabled voice in turn, and drives the existing DAC SPI transmitter's `data_in`/`send` pair with correctly channel-addressed 24-bit words. It replaces the per-voice sample timer, so several voices share one DAC without colliding SPI frames.

---
 rtl/dac_channel_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dac_channel_scheduler.sv
// rtl/dac_channel_scheduler.sv - per-sample MAX5134 channel sequencer for up to four voices
module dac_channel_scheduler #(
    parameter int SAMPLEINTERVAL = 1909,
    parameter int SEND_GAP       = 64,
    parameter int REQ_TIMEOUT    = 16
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [3:0]  ch_enable_i,
    input  logic [3:0]  sample_valid_i,
    input  logic [63:0] sample_in_i,
    input  logic        err_clr_i,
    output logic [3:0]  sample_req_o,
    output logic [23:0] dac_data_o,
    output logic        dac_send_o,
    output logic        sample_tick_o,
    output logic        busy_o,
    output logic        overrun_o,
    output logic        underrun_o
);
    localparam int TW   = (SAMPLEINTERVAL > 1) ? $clog2(SAMPLEINTERVAL) : 1;
    localparam int CMAX = (REQ_TIMEOUT > SEND_GAP) ? REQ_TIMEOUT : SEND_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLEINTERVAL - 1);
    localparam logic [CW-1:0] REQ_LAST   = CW'(REQ_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(SEND_GAP - 2);

    typedef enum logic [2:0] {IDLE, REQ, LOAD, SEND, GAP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          tick_q, tick_d;
    logic [3:0]    mask_q, mask_d;
    logic [1:0]    chan_q, chan_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   hold_q [4];
    logic [15:0]   hold_d [4];
    logic [3:0]    req_q, req_d;
    logic [23:0]   data_q, data_d;
    logic          send_q, send_d;
    logic          busy_q, busy_d;
    logic          ovr_q, ovr_d;
    logic          unr_q, unr_d;
    logic [15:0]   sample_c;
    logic [7:0]    cmd_c;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    always_comb begin
        tick_d   = (timer_q == TIMER_LAST);
        timer_d  = tick_d ? '0 : timer_q + 1'b1;
        state_d  = state_q;
        mask_d   = mask_q;
        chan_d   = chan_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        data_d   = data_q;
        ovr_d    = ovr_q & ~err_clr_i;
        unr_d    = unr_q & ~err_clr_i;
        sample_c = sample_in_i[{chan_q, 4'b0000} +: 16];
        cmd_c    = {4'b0011, onehot(chan_q)};

        // A tick that lands mid-frame is dropped; only the sticky flag records it.
        if (tick_q && state_q != IDLE) ovr_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (tick_q) begin
                    mask_d = ch_enable_i;
                    if (ch_enable_i != 4'b0) begin
                        chan_d  = lowest(ch_enable_i);
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (sample_valid_i[chan_q]) begin
                    hold_d[chan_q] = sample_c;
                    data_d         = {cmd_c, sample_c};
                    state_d        = LOAD;
                end else if (cnt_q == REQ_LAST) begin
                    unr_d   = 1'b1;
                    data_d  = {cmd_c, hold_q[chan_q]};
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: state_d = SEND;
            SEND: begin
                cnt_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    mask_d = mask_q & ~onehot(chan_q);
                    if (mask_d != 4'b0) begin
                        chan_d  = lowest(mask_d);
                        cnt_d   = '0;
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state implies.
        req_d  = (state_d == REQ) ? onehot(chan_d) : 4'b0;
        send_d = (state_d == SEND);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            tick_q  <= 1'b0;
            mask_q  <= 4'b0;
            chan_q  <= 2'd0;
            cnt_q   <= '0;
            hold_q  <= '{default: 16'h8000};
            req_q   <= 4'b0;
            data_q  <= 24'h000000;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            unr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            tick_q  <= tick_d;
            mask_q  <= mask_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            req_q   <= req_d;
            data_q  <= data_d;
            send_q  <= send_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            unr_q   <= unr_d;
        end
    end

    assign sample_req_o  = req_q;
    assign dac_data_o    = data_q;
    assign dac_send_o    = send_q;
    assign sample_tick_o = tick_q;
    assign busy_o        = busy_q;
    assign overrun_o     = ovr_q;
    assign underrun_o    = unr_q;
endmodule
